// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two requesters.
// The granted request drives the ALU combinationally and its result is
// captured into a one-entry response buffer owned by that requester.
module alu_share_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   // Request port 0
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   // Request port 1
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   // Response port 0
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp0_err,
   // Response port 1
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_data,
   output logic              rsp1_err,
   // Shared ALU
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] operand_a,
   output logic [DATA_W-1:0] operand_b,
   input  logic [DATA_W-1:0] alu_data
);

   // Opcodes the ALU implements; anything else is accepted but reported as an error.
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         OP_W'(4'h0), OP_W'(4'h1), OP_W'(4'h2), OP_W'(4'h3),
         OP_W'(4'h4), OP_W'(4'h5), OP_W'(4'h6), OP_W'(4'h7),
         OP_W'(4'h8), OP_W'(4'hb), OP_W'(4'hd): legal = 1'b1;
         default:                               legal = 1'b0;
      endcase
      return legal;
   endfunction

   logic              rsp0_valid_q, rsp0_valid_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
   logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
   logic              rsp0_err_q, rsp0_err_d;
   logic              rsp1_err_q, rsp1_err_d;
   // 0: port 0 was granted last, 1: port 1 was granted last.
   logic              last_grant_q, last_grant_d;

   logic              slot_free0, slot_free1;
   logic              elig0, elig1;
   logic              grant0, grant1;
   logic              accept_legal;
   logic [DATA_W-1:0] accept_data;

   // A buffer being drained this cycle can be refilled in the same cycle.
   assign slot_free0 = ~rsp0_valid_q | rsp0_ready;
   assign slot_free1 = ~rsp1_valid_q | rsp1_ready;
   assign elig0      = req0_valid & slot_free0;
   assign elig1      = req1_valid & slot_free1;

   // Round-robin grant: a tie goes to the port that was not granted last.
   always_comb begin
      grant0 = elig0 & (~elig1 | last_grant_q);
      grant1 = elig1 & (~elig0 | ~last_grant_q);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Forward the granted request to the ALU; idle bus is all zeros.
   always_comb begin
      alu_op    = '0;
      operand_a = '0;
      operand_b = '0;
      if (grant0) begin
         alu_op    = req0_op;
         operand_a = req0_a;
         operand_b = req0_b;
      end else if (grant1) begin
         alu_op    = req1_op;
         operand_a = req1_a;
         operand_b = req1_b;
      end
   end

   assign accept_legal = op_legal(alu_op);
   assign accept_data  = accept_legal ? alu_data : '0;

   // Response buffer and round-robin pointer next state.
   always_comb begin
      rsp0_valid_d = rsp0_valid_q;
      rsp0_data_d  = rsp0_data_q;
      rsp0_err_d   = rsp0_err_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp1_data_d  = rsp1_data_q;
      rsp1_err_d   = rsp1_err_q;
      last_grant_d = last_grant_q;
      if (grant0) begin
         rsp0_valid_d = 1'b1;
         rsp0_data_d  = accept_data;
         rsp0_err_d   = ~accept_legal;
         last_grant_d = 1'b0;
      end else if (rsp0_ready) begin
         rsp0_valid_d = 1'b0;
      end
      if (grant1) begin
         rsp1_valid_d = 1'b1;
         rsp1_data_d  = accept_data;
         rsp1_err_d   = ~accept_legal;
         last_grant_d = 1'b1;
      end else if (rsp1_ready) begin
         rsp1_valid_d = 1'b0;
      end
   end

   // State registers; reset leaves port 0 winning the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp0_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp0_err_q   <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp1_data_q  <= '0;
         rsp1_err_q   <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         rsp0_valid_q <= rsp0_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp0_err_q   <= rsp0_err_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp1_data_q  <= rsp1_data_d;
         rsp1_err_q   <= rsp1_err_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp0_err   = rsp0_err_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp1_data  = rsp1_data_q;
   assign rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp0_err;
   logic        rsp1_valid, rsp1_ready, rsp1_err;
   logic [31:0] rsp0_data, rsp1_data;
   logic [3:0]  alu_op;
   logic [31:0] operand_a, operand_b, alu_data;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model state: one buffer per port and the port granted last.
   logic        m_valid[2];
   logic [31:0] m_data[2];
   logic        m_err[2];
   int          m_last;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .rsp1_err(rsp1_err),
      .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b), .alu_data(alu_data)
   );

   // Behavioural ALU; unknown opcodes return junk so zeroing is observable.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [31:0] r;
      case (op)
         4'h0: r = a + b;
         4'h8: r = a - b;
         4'h2: r = {31'd0, $signed(a) < $signed(b)};
         4'h3: r = {31'd0, a < b};
         4'h4: r = a ^ b;
         4'h6: r = a | b;
         4'h7: r = a & b;
         4'h1: r = a << b[4:0];
         4'h5: r = a >> b[4:0];
         4'hd: r = $signed(a) >>> b[4:0];
         4'hb: r = b;
         default: r = 32'hDEAD_BEEF;
      endcase
      return r;
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return op inside {4'h9, 4'ha, 4'hc, 4'he, 4'hf};
   endfunction

   always_comb alu_data = alu_fn(alu_op, operand_a, operand_b);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests_run++;
      if ({rsp0_valid, rsp0_err, rsp0_data} !== 34'd0) begin
         tests_failed++;
         $display("FAIL reset_rsp0: got v=%0b e=%0b d=%h want all 0", rsp0_valid, rsp0_err,
                  rsp0_data);
      end
      tests_run++;
      if ({rsp1_valid, rsp1_err, rsp1_data} !== 34'd0) begin
         tests_failed++;
         $display("FAIL reset_rsp1: got v=%0b e=%0b d=%h want all 0", rsp1_valid, rsp1_err,
                  rsp1_data);
      end
      tests_run++;
      if ({req0_ready, req1_ready, alu_op, operand_a, operand_b} !== 70'd0) begin
         tests_failed++;
         $display("FAIL reset_idle_bus: got r0=%0b r1=%0b op=%h a=%h b=%h want all 0",
                  req0_ready, req1_ready, alu_op, operand_a, operand_b);
      end
   endtask

   task automatic test_single_op();
      do_reset();
      req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd5; req0_b = 32'd3;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
      end
      tests_run++;
      if (alu_op !== 4'h0 || operand_a !== 32'd5 || operand_b !== 32'd3) begin
         tests_failed++;
         $display("FAIL single_alu_drive: got op=%h a=%h b=%h want 0/5/3", alu_op, operand_a,
                  operand_b);
      end
      step();
      req0_valid = 1'b0;
      #1;
      tests_run++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd8 || rsp0_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_rsp: got v=%0b d=%h e=%0b want 1/8/0", rsp0_valid, rsp0_data,
                  rsp0_err);
      end
      step();
      tests_run++;
      if (rsp0_valid !== 1'b0 || rsp0_data !== 32'd8) begin
         tests_failed++;
         $display("FAIL single_drain: got v=%0b d=%h want 0/8", rsp0_valid, rsp0_data);
      end
   endtask

   task automatic test_round_robin();
      int exp_g;
      do_reset();
      req0_valid = 1'b1; req0_op = 4'h8; req0_a = 32'd10;         req0_b = 32'd3;
      req1_valid = 1'b1; req1_op = 4'h2; req1_a = 32'hFFFF_FFFF;  req1_b = 32'd1;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL rr_first_tie: got %b%b want 10", req0_ready, req1_ready);
      end
      step();
      tests_run++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd7) begin
         tests_failed++;
         $display("FAIL rr_rsp0: got v=%0b d=%h want 1/7", rsp0_valid, rsp0_data);
      end
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL rr_second: got %b%b want 01", req0_ready, req1_ready);
      end
      step();
      tests_run++;
      if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd1 || rsp1_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL rr_rsp1: got v=%0b d=%h e=%0b want 1/1/0", rsp1_valid, rsp1_data,
                  rsp1_err);
      end
      exp_g = 0;
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (req0_ready !== (exp_g == 0) || req1_ready !== (exp_g == 1)) begin
            tests_failed++;
            $display("FAIL rr_alternate[%0d]: got %b%b want port %0d", i, req0_ready,
                     req1_ready, exp_g);
         end
         step();
         exp_g = 1 - exp_g;
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd5; req0_b = 32'd3;
      step();
      req0_op = 4'h4; req0_a = 32'h0000_0F0F; req0_b = 32'h0000_00FF;
      req1_valid = 1'b1; req1_op = 4'h6; req1_a = 32'hF0; req1_b = 32'h0F;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL bp_stall: got %b%b want 01", req0_ready, req1_ready);
      end
      step();
      req1_valid = 1'b0;
      #1;
      tests_run++;
      if (rsp1_valid !== 1'b1 || rsp1_data !== 32'hFF) begin
         tests_failed++;
         $display("FAIL bp_other_served: got v=%0b d=%h want 1/ff", rsp1_valid, rsp1_data);
      end
      tests_run++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd8 || rsp0_err !== 1'b0 || req0_ready !== 1'b0)
      begin
         tests_failed++;
         $display("FAIL bp_hold: got v=%0b d=%h e=%0b rdy=%0b want 1/8/0/0", rsp0_valid,
                  rsp0_data, rsp0_err, req0_ready);
      end
      rsp0_ready = 1'b1;
      #1;
      tests_run++;
      if (req0_ready !== 1'b1 || alu_op !== 4'h4) begin
         tests_failed++;
         $display("FAIL bp_release_grant: got rdy=%0b op=%h want 1/4", req0_ready, alu_op);
      end
      step();
      req0_valid = 1'b0;
      #1;
      tests_run++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h0000_0FF0) begin
         tests_failed++;
         $display("FAIL bp_xor_rsp: got v=%0b d=%h want 1/00000ff0", rsp0_valid, rsp0_data);
      end
      idle_inputs();
   endtask

   task automatic test_illegal();
      do_reset();
      req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd1; req0_b = 32'd1;
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = 4'h9; req1_a = 32'd1; req1_b = 32'd1;
      #1;
      tests_run++;
      if (req1_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL illegal_accept: got rdy=%0b want 1", req1_ready);
      end
      step();
      tests_run++;
      if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd0 || rsp1_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL illegal_rsp: got v=%0b d=%h e=%0b want 1/0/1", rsp1_valid, rsp1_data,
                  rsp1_err);
      end
      req0_valid = 1'b1; req0_op = 4'h7; req0_a = 32'hFF; req0_b = 32'h3C;
      req1_op = 4'h3;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL illegal_turn: got %b%b want 10", req0_ready, req1_ready);
      end
      step();
      #1;
      tests_run++;
      if (rsp0_data !== 32'h3C || {req0_ready, req1_ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL illegal_after: got d=%h rdy=%b%b want 3c/01", rsp0_data, req0_ready,
                  req1_ready);
      end
      step();
      tests_run++;
      if (rsp1_err !== 1'b0 || rsp1_data !== 32'd0) begin
         tests_failed++;
         $display("FAIL illegal_clear_err: got e=%0b d=%h want 0/0", rsp1_err, rsp1_data);
      end
      idle_inputs();
   endtask

   task automatic test_shift();
      do_reset();
      req0_valid = 1'b1; req0_op = 4'hd; req0_a = 32'h8000_0000; req0_b = 32'd4;
      step();
      tests_run++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 32'hF800_0000) begin
         tests_failed++;
         $display("FAIL shift_sra: got v=%0b d=%h want 1/f8000000", rsp0_valid, rsp0_data);
      end
      req0_op = 4'hb; req0_a = 32'd0; req0_b = 32'h1234_5000;
      step();
      req0_valid = 1'b0;
      #1;
      tests_run++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h1234_5000) begin
         tests_failed++;
         $display("FAIL shift_lui: got v=%0b d=%h want 1/12345000", rsp0_valid, rsp0_data);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      rsp1_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 4'h0; req1_a = 32'd2; req1_b = 32'd2;
      step();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd9; req0_b = 32'd9;
      rst = 1'b1;
      step();
      rst = 1'b0;
      req0_valid = 1'b0;
      #1;
      tests_run++;
      if ({rsp0_valid, rsp0_err, rsp0_data, rsp1_valid, rsp1_err, rsp1_data} !== 68'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_clear: got v0=%0b d0=%h e0=%0b v1=%0b d1=%h e1=%0b want 0",
                  rsp0_valid, rsp0_data, rsp0_err, rsp1_valid, rsp1_data, rsp1_err);
      end
      rsp1_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("FAIL reset_mid_tie: got %b%b want 10", req0_ready, req1_ready);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      logic        vld[2], rdy[2], elig[2];
      logic [3:0]  op[2];
      logic [31:0] a[2], b[2];
      logic [3:0]  exp_op;
      logic [31:0] exp_a, exp_b;
      int          exp_g;
      do_reset();
      for (int p = 0; p < 2; p++) begin
         m_valid[p] = 1'b0; m_data[p] = '0; m_err[p] = 1'b0;
      end
      m_last = 1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            vld[p] = ($urandom_range(0, 3) != 0);
            rdy[p] = ($urandom_range(0, 3) != 0);
            op[p]  = 4'($urandom_range(0, 15));
            a[p]   = $urandom;
            b[p]   = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
         end
         req0_valid = vld[0]; req0_op = op[0]; req0_a = a[0]; req0_b = b[0];
         req1_valid = vld[1]; req1_op = op[1]; req1_a = a[1]; req1_b = b[1];
         rsp0_ready = rdy[0]; rsp1_ready = rdy[1];
         #1;
         for (int p = 0; p < 2; p++) elig[p] = vld[p] && (!m_valid[p] || rdy[p]);
         if (elig[0] && elig[1]) exp_g = 1 - m_last;
         else if (elig[0])       exp_g = 0;
         else if (elig[1])       exp_g = 1;
         else                    exp_g = -1;
         exp_op = (exp_g >= 0) ? op[exp_g] : 4'h0;
         exp_a  = (exp_g >= 0) ? a[exp_g]  : 32'h0;
         exp_b  = (exp_g >= 0) ? b[exp_g]  : 32'h0;
         tests_run++;
         if (rsp0_valid !== m_valid[0] || rsp0_data !== m_data[0] || rsp0_err !== m_err[0])
         begin
            tests_failed++;
            $display("FAIL rand_rsp0[%0d]: got v=%0b d=%h e=%0b want %0b/%h/%0b", cyc,
                     rsp0_valid, rsp0_data, rsp0_err, m_valid[0], m_data[0], m_err[0]);
         end
         tests_run++;
         if (rsp1_valid !== m_valid[1] || rsp1_data !== m_data[1] || rsp1_err !== m_err[1])
         begin
            tests_failed++;
            $display("FAIL rand_rsp1[%0d]: got v=%0b d=%h e=%0b want %0b/%h/%0b", cyc,
                     rsp1_valid, rsp1_data, rsp1_err, m_valid[1], m_data[1], m_err[1]);
         end
         tests_run++;
         if (req0_ready !== (exp_g == 0) || req1_ready !== (exp_g == 1)) begin
            tests_failed++;
            $display("FAIL rand_grant[%0d]: got %b%b want port %0d", cyc, req0_ready,
                     req1_ready, exp_g);
         end
         tests_run++;
         if (alu_op !== exp_op || operand_a !== exp_a || operand_b !== exp_b) begin
            tests_failed++;
            $display("FAIL rand_alu[%0d]: got %h/%h/%h want %h/%h/%h", cyc, alu_op,
                     operand_a, operand_b, exp_op, exp_a, exp_b);
         end
         step();
         for (int p = 0; p < 2; p++) begin
            if (exp_g == p) begin
               m_valid[p] = 1'b1;
               m_err[p]   = is_illegal(op[p]);
               m_data[p]  = is_illegal(op[p]) ? 32'h0 : alu_fn(op[p], a[p], b[p]);
               m_last     = p;
            end else if (rdy[p]) begin
               m_valid[p] = 1'b0;
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_single_op();
      test_round_robin();
      test_backpressure();
      test_illegal();
      test_shift();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
